// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator control path.
//   op_e    - operation code encoding driven by the op switches
//   state_e - calc_sequencer FSM states
//   ACC_W, ACC_MAX, ACC_MIN - accumulator width and saturation limits
package calc_pkg;

  localparam int ACC_W = 8;
  localparam logic [ACC_W-1:0] ACC_MAX = 8'h7F;
  localparam logic [ACC_W-1:0] ACC_MIN = 8'h80;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    EXEC      = 2'b01,
    WAIT_CONV = 2'b10
  } state_e;

endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: three-flop synchroniser for an asynchronous key level,
// followed by a rising-edge detector. Shared by all calculator keys.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   key_i   - raw key level, asynchronous to clk
//   edge_o  - one-cycle pulse on a synchronised rising edge
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic edge_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], key_i};
    end
  end

  // sync_q[1] is q1, sync_q[2] is q2
  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM for the 8-bit signed calculator. Each go-key
// press executes one command on the accumulator, then waits for the display
// converter to acknowledge with 'change' (or times out) before returning idle.
// Build option: define CALC_SAT_EN to saturate ADD/SUB overflow instead of
// wrapping.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   key_go         - raw go key level
//   op, operand    - command and two's-complement operand, sampled in EXEC
//   change         - converter completion pulse
//   accumulator    - registered result feeding the converter
//   ovf, disp_err  - sticky overflow / converter-timeout flags
//   busy, done     - command in progress / one-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a go-key edge
// EXEC      | one cycle: compute and register the new accumulator value
// WAIT_CONV | waiting for the converter's change pulse or timeout
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int CONV_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_go,
  input  logic [1:0]       op,
  input  logic [ACC_W-1:0] operand,
  input  logic             change,
  output logic [ACC_W-1:0] accumulator,
  output logic             ovf,
  output logic             disp_err,
  output logic             busy,
  output logic             done
);

  // Down-counter loaded on entry to WAIT_CONV; terminal count 0 corresponds
  // to the CONV_TIMEOUT-th cycle spent waiting.
  localparam logic [7:0] TMR_LOAD = 8'(CONV_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [7:0]       tmr_q, tmr_d;
  logic             busy_q, done_q;
  logic             go_edge;

  op_e              op_s;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] res;

  key_sync_edge u_go_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_i  (key_go),
    .edge_o (go_edge)
  );

  assign op_s = op_e'(op);

  always_comb begin
    sum     = {acc_q[ACC_W-1], acc_q};
    sum_ovf = 1'b0;
    res     = acc_q;
    unique case (op_s)
      OP_ADD:   sum = {acc_q[ACC_W-1], acc_q} + {operand[ACC_W-1], operand};
      OP_SUB:   sum = {acc_q[ACC_W-1], acc_q} - {operand[ACC_W-1], operand};
      default:  sum = {acc_q[ACC_W-1], acc_q};
    endcase
    if (op_s == OP_ADD || op_s == OP_SUB) begin
      sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef CALC_SAT_EN
      // sum[ACC_W] carries the true sign of the unbounded result
      if (sum_ovf) res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      else         res = sum[ACC_W-1:0];
`else
      res = sum[ACC_W-1:0];
`endif
    end else if (op_s == OP_LOAD) begin
      res = operand;
    end else begin
      res = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (go_edge) state_d = EXEC;
      end
      EXEC: begin
        acc_d = res;
        if (op_s == OP_CLEAR) begin
          ovf_d = 1'b0;
          err_d = 1'b0;
        end else if (sum_ovf) begin
          ovf_d = 1'b1;
        end
        if (res == acc_q) begin
          state_d = IDLE;
        end else begin
          tmr_d   = TMR_LOAD;
          state_d = WAIT_CONV;
        end
      end
      WAIT_CONV: begin
        // change takes priority over a coincident timeout
        if (change) begin
          state_d = IDLE;
        end else if (tmr_q == 8'd0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  assign accumulator = acc_q;
  assign ovf         = ovf_q;
  assign disp_err    = err_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the 8-bit signed calculator datapath. Accepts a switch operand and an operation code on each press of the go key, and updates the two's-complement accumulator that feeds the binary-to-decimal display converter. After each update it waits for the converter's `change` completion pulse before accepting the next command, so the display never lags behind a queued operation.

## Interface
Parameters:
- `CONV_TIMEOUT`, default 32: maximum cycles spent in WAIT_CONV before the converter is declared unresponsive (valid range 16–255).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `key_go`  in  1  raw go key, level, asynchronous to `clk`, active-high
- `op`  in  2  operation code, sampled in EXEC: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- `operand`  in  8  two's-complement switch operand, sampled in EXEC
- `change`  in  1  converter completion pulse, 1 cycle
- `accumulator`  out  8  registered two's-complement result, drives the converter
- `ovf`  out  1  sticky signed-overflow flag
- `disp_err`  out  1  sticky converter-timeout flag
- `busy`  out  1  high in EXEC and WAIT_CONV
- `done`  out  1  1-cycle pulse on return to IDLE after a command

## Operation
- Reset values: `accumulator`=0x00, `ovf`=0, `disp_err`=0, `busy`=0, `done`=0, state IDLE, synchroniser flops 0.
- `key_go` passes through three flops q0→q1→q2; `go_edge` = q1 & ~q2.
- States:
  - IDLE: if `go_edge`, go to EXEC; otherwise stay.
  - EXEC: 1 cycle. Computes the result and registers it into `accumulator` at the cycle's closing edge. If the new value equals the old value, go to IDLE and pulse `done`. Otherwise clear the timeout counter and go to WAIT_CONV.
  - WAIT_CONV: on `change`=1, go to IDLE and pulse `done`. When the counter reaches CONV_TIMEOUT−1, set `disp_err`, go to IDLE and pulse `done`.
- Arithmetic: both operands are sign-extended to 9 bits.
  - ADD = acc+operand; SUB = acc−operand.
  - Overflow occurs when sum[8] ≠ sum[7]; on overflow, set `ovf` (sticky).
  - LOAD: acc=operand; `ovf` unchanged.
  - CLEAR: acc=0, `ovf`=0, `disp_err`=0.
- `go_edge` outside IDLE is dropped, not queued.
- A `change` pulse outside WAIT_CONV is ignored.
- Reset asserted mid-operation returns everything to reset values immediately; the in-flight command is lost.

## Timing
- A `key_go` rise first sampled at edge N produces `go_edge` high between N+1 and N+2. IDLE→EXEC at N+2; `accumulator` updates at N+3.
- Converter response: `change` arrives 6–16 cycles after `accumulator` updates. Value 0x80 takes the longest (magnitude 128).
- `done` is high for exactly the cycle after the transition into IDLE.
- Command-to-command minimum: 2 cycles for an unchanged result, at most CONV_TIMEOUT+2 otherwise.
- If `change` and timeout coincide, `change` wins and `disp_err` is not set.
- `busy` is registered and is high from N+2 up to and including the final WAIT_CONV cycle.

## Configuration
- `CALC_SAT_EN` defined: on ADD/SUB overflow, `accumulator` saturates to 0x7F (positive overflow) or 0x80 (negative overflow), and `ovf` is still set.
- `CALC_SAT_EN` undefined: the result wraps (low 8 bits of the 9-bit sum) and `ovf` is set.

## Structure
- `calc_pkg` holds:
  - the op encoding enum (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR);
  - the state enum (IDLE, EXEC, WAIT_CONV);
  - constants ACC_W=8 and ACC_MAX/ACC_MIN for saturation.
- Sub-module `key_sync_edge`: the three-flop synchroniser plus rising-edge detect, with async active-low reset. It is reused for the other calculator keys.

## Test plan
- Reset then LOAD operand 0x05 → `accumulator`=0x05 at N+3; inject `change` 8 cycles later → `done` pulse; `busy` low afterwards.
- acc=0x7F, ADD 0x01 → wrap build gives 0x80 with `ovf`=1; `CALC_SAT_EN` build gives 0x7F with `ovf`=1.
- acc=0x10, SUB 0x00 → value unchanged, EXEC→IDLE directly, `done` at N+3, no WAIT_CONV.
- LOAD 0x22 with `change` withheld → `disp_err`=1 after 32 cycles and return to IDLE; a following CLEAR → acc=0, `ovf`=0, `disp_err`=0.
- Second `key_go` press during WAIT_CONV → ignored and `accumulator` unchanged. Also: deassert `rst_n` mid-WAIT_CONV → all outputs reset asynchronously.
